// File: rtl/poly_voice_mixer.sv
`default_nettype none
// ============================================================================
// Module   : poly_voice_mixer
// Brief    : Voice allocator and mixer for a pool of NUM_VOICES external
//            WaveGen voices. Allocates noteOn events with one-cycle go
//            pulses, releases voices on a matching noteOff, and mixes the
//            active voices into one saturated sample under a ready/received
//            handshake.
//            Optional feature macro: VOICE_STEAL_EN (round-robin voice
//            stealing when the pool is full; default build drops the note).
// Revision : 1.0 - initial parametrised release
// ============================================================================
module poly_voice_mixer #(
    parameter int NUM_VOICES = 8,
    parameter int SAMPLE_W   = 18,
    parameter int DELAY_W    = 10,
    parameter int VEL_W      = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           noteOn,
    input  logic                           noteOff,
    input  logic [DELAY_W-1:0]             delay,
    input  logic [VEL_W-1:0]               velocity,
    input  logic [NUM_VOICES-1:0]          voicePrepped,
    input  logic [NUM_VOICES-1:0]          voiceReady,
    input  logic [NUM_VOICES*SAMPLE_W-1:0] voiceData,
    output logic [NUM_VOICES-1:0]          voiceGo,
    output logic [NUM_VOICES-1:0]          voiceKill,
    output logic [DELAY_W-1:0]             voiceDelay,
    output logic [VEL_W-1:0]               voiceVel,
    output logic [NUM_VOICES-1:0]          activeMask,
    output logic                           dropped,
    output logic                           ready,
    input  logic                           received,
    output logic [SAMPLE_W-1:0]            dataOut
);

    localparam int c_SUM_W = SAMPLE_W + $clog2(NUM_VOICES);
    localparam logic signed [c_SUM_W-1:0] c_SAT_MAX =
        {{(c_SUM_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [c_SUM_W-1:0] c_SAT_MIN =
        {{(c_SUM_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

    // Registered state
    logic                  r_on_d;
    logic                  r_off_d;
    logic [NUM_VOICES-1:0] r_prepped_d;
    logic [NUM_VOICES-1:0] r_go;
    logic [NUM_VOICES-1:0] r_go_d1;
    logic [NUM_VOICES-1:0] r_kill;
    logic [NUM_VOICES-1:0] r_mask;
    logic [DELAY_W-1:0]    r_delay;
    logic [VEL_W-1:0]      r_vel;
    logic                  r_dropped;
    logic                  r_ready;
    logic [SAMPLE_W-1:0]   r_data;

    // Combinational control
    logic                  w_on_edge;
    logic                  w_off_edge;
    logic [NUM_VOICES-1:0] w_tag_hit;
    logic [NUM_VOICES-1:0] w_kill_rel;
    logic [NUM_VOICES-1:0] w_free;
    logic [NUM_VOICES-1:0] w_alloc;
    logic                  w_no_free;
    logic [NUM_VOICES-1:0] w_steal_kill;
    logic                  w_drop;
    logic [NUM_VOICES-1:0] w_pend_mask;
    logic [DELAY_W-1:0]    w_pend_tag;
    logic [VEL_W-1:0]      w_pend_vel;
    logic [NUM_VOICES-1:0] w_go_next;
    logic [NUM_VOICES-1:0] w_nat_end;
    logic [NUM_VOICES-1:0] w_mask_next;
    logic signed [c_SUM_W-1:0] w_sum;
    logic signed [c_SUM_W-1:0] w_sat;
    logic                  w_capture;

    assign w_on_edge  = noteOn  & ~r_on_d;
    assign w_off_edge = noteOff & ~r_off_d;

    // Release: every active voice whose tag matches the noteOff tag
    assign w_kill_rel = {NUM_VOICES{w_off_edge}} & r_mask & w_tag_hit;

    // A voice is free only when idle and not owned; a voice released this
    // cycle is still owned, so it can never be reused in the same cycle.
    assign w_free    = voicePrepped & ~r_mask;
    // Lowest set bit of the free vector
    assign w_alloc   = w_on_edge ? (w_free & (~w_free + NUM_VOICES'(1))) : '0;
    assign w_no_free = w_on_edge & (w_free == '0);

`ifdef VOICE_STEAL_EN
    localparam int c_PTR_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    logic [c_PTR_W-1:0]    r_steal_ptr;
    logic [NUM_VOICES-1:0] r_steal_mask;
    logic [DELAY_W-1:0]    r_steal_tag;
    logic [VEL_W-1:0]      r_steal_vel;

    assign w_steal_kill = w_no_free ? (NUM_VOICES'(1) << r_steal_ptr) : '0;
    assign w_drop       = 1'b0;
    assign w_pend_mask  = r_steal_mask;
    assign w_pend_tag   = r_steal_tag;
    assign w_pend_vel   = r_steal_vel;

    // Steal bookkeeping: kill now, re-start the same voice one cycle later
    always_ff @(posedge clk) begin
        if (reset) begin
            r_steal_ptr  <= '0;
            r_steal_mask <= '0;
            r_steal_tag  <= '0;
            r_steal_vel  <= '0;
        end else begin
            r_steal_mask <= w_steal_kill;
            if (w_no_free) begin
                r_steal_tag <= delay;
                r_steal_vel <= velocity;
                if (r_steal_ptr == c_PTR_W'(NUM_VOICES - 1)) begin
                    r_steal_ptr <= '0;
                end else begin
                    r_steal_ptr <= r_steal_ptr + c_PTR_W'(1);
                end
            end
        end
    end
`else
    assign w_steal_kill = '0;
    assign w_drop       = w_no_free;
    assign w_pend_mask  = '0;
    assign w_pend_tag   = '0;
    assign w_pend_vel   = '0;
`endif

    assign w_go_next = w_alloc | w_pend_mask;

    // Natural end: voice reports idle again long after its go, and it is not
    // the target of a steal in flight.
    assign w_nat_end = voicePrepped & ~r_prepped_d & r_mask & ~(r_go | r_go_d1)
                     & ~w_pend_mask;

    assign w_mask_next = (r_mask & ~w_kill_rel & ~w_nat_end) | w_go_next;

    // Per-voice note tag storage and tag match
    generate
        for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
            logic [DELAY_W-1:0] r_tag;

            // Tag is written with the voice's go, from the live noteOn or a pending steal
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_tag <= '0;
                end else if (w_alloc[gi]) begin
                    r_tag <= delay;
                end else if (w_pend_mask[gi]) begin
                    r_tag <= w_pend_tag;
                end
            end

            assign w_tag_hit[gi] = (r_tag == delay);
        end
    endgenerate

    // Allocation, release and edge-detect state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_on_d      <= 1'b0;
            r_off_d     <= 1'b0;
            r_prepped_d <= '0;
            r_go        <= '0;
            r_go_d1     <= '0;
            r_kill      <= '0;
            r_mask      <= '0;
            r_delay     <= '0;
            r_vel       <= '0;
            r_dropped   <= 1'b0;
        end else begin
            r_on_d      <= noteOn;
            r_off_d     <= noteOff;
            r_prepped_d <= voicePrepped;
            r_go        <= w_go_next;
            r_go_d1     <= r_go;
            r_kill      <= w_kill_rel | w_steal_kill;
            r_mask      <= w_mask_next;
            r_dropped   <= w_drop;
            if (w_alloc != '0) begin
                r_delay <= delay;
                r_vel   <= velocity;
            end else if (w_pend_mask != '0) begin
                r_delay <= w_pend_tag;
                r_vel   <= w_pend_vel;
            end
        end
    end

    // Sign-extended sum of active voices, then clamp to the sample range
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (r_mask[i]) begin
                w_sum = w_sum + c_SUM_W'($signed(voiceData[i*SAMPLE_W +: SAMPLE_W]));
            end
        end
        w_sat = w_sum;
        if (w_sum > c_SAT_MAX) begin
            w_sat = c_SAT_MAX;
        end else if (w_sum < c_SAT_MIN) begin
            w_sat = c_SAT_MIN;
        end
    end

    assign w_capture = (r_mask != '0) && ((voiceReady & r_mask) == r_mask) && !r_ready;

    // Output frame register: capture when idle, hold until received
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ready <= 1'b0;
            r_data  <= '0;
        end else if (w_capture) begin
            r_ready <= 1'b1;
            r_data  <= w_sat[SAMPLE_W-1:0];
        end else if (r_ready && received) begin
            r_ready <= 1'b0;
        end
    end

    assign voiceGo    = r_go;
    assign voiceKill  = r_kill;
    assign voiceDelay = r_delay;
    assign voiceVel   = r_vel;
    assign activeMask = r_mask;
    assign dropped    = r_dropped;
    assign ready      = r_ready;
    assign dataOut    = r_data;

endmodule
`default_nettype wire

// File: tb/tb_poly_voice_mixer.sv
`default_nettype none
// ============================================================================
// Module   : tb_poly_voice_mixer
// Brief    : Directed self-checking bench for poly_voice_mixer (8 voices,
//            18-bit samples). Expectations follow VOICE_STEAL_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_poly_voice_mixer;

    localparam int NV = 8;
    localparam int SW = 18;
    localparam int DW = 10;
    localparam int VW = 8;

`ifdef VOICE_STEAL_EN
    localparam bit c_STEAL = 1'b1;
`else
    localparam bit c_STEAL = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             noteOn;
    logic             noteOff;
    logic [DW-1:0]    delay;
    logic [VW-1:0]    velocity;
    logic [NV-1:0]    voicePrepped;
    logic [NV-1:0]    voiceReady;
    logic [NV*SW-1:0] voiceData;
    logic [NV-1:0]    voiceGo;
    logic [NV-1:0]    voiceKill;
    logic [DW-1:0]    voiceDelay;
    logic [VW-1:0]    voiceVel;
    logic [NV-1:0]    activeMask;
    logic             dropped;
    logic             ready;
    logic             received;
    logic [SW-1:0]    dataOut;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    poly_voice_mixer #(
        .NUM_VOICES(NV), .SAMPLE_W(SW), .DELAY_W(DW), .VEL_W(VW)
    ) u_dut (
        .clk(clk), .reset(reset), .noteOn(noteOn), .noteOff(noteOff),
        .delay(delay), .velocity(velocity), .voicePrepped(voicePrepped),
        .voiceReady(voiceReady), .voiceData(voiceData), .voiceGo(voiceGo),
        .voiceKill(voiceKill), .voiceDelay(voiceDelay), .voiceVel(voiceVel),
        .activeMask(activeMask), .dropped(dropped), .ready(ready),
        .received(received), .dataOut(dataOut)
    );

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_all_data(input logic [SW-1:0] v);
        for (int i = 0; i < NV; i++) voiceData[i*SW +: SW] = v;
    endtask

    task automatic pulse_on(input logic [DW-1:0] d, input logic [VW-1:0] v);
        delay    = d;
        velocity = v;
        noteOn   = 1'b1;
        tick();
    endtask

    task automatic drop_on();
        noteOn = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1; noteOn = 1'b0; noteOff = 1'b0; delay = '0; velocity = '0;
        voicePrepped = '1; voiceReady = '0; voiceData = '0; received = 1'b0;
        tick(); tick();
        check_value("rst_go",      32'(voiceGo),    32'h0);
        check_value("rst_kill",    32'(voiceKill),  32'h0);
        check_value("rst_mask",    32'(activeMask), 32'h0);
        check_value("rst_dropped", 32'(dropped),    32'h0);
        check_value("rst_ready",   32'(ready),      32'h0);
        check_value("rst_data",    32'(dataOut),    32'h0);
        reset = 1'b0;
        tick();

        // Allocation of the first note to voice 0
        pulse_on(10'd100, 8'd50);
        check_value("alloc0_go",    32'(voiceGo),    32'h01);
        check_value("alloc0_mask",  32'(activeMask), 32'h01);
        check_value("alloc0_delay", 32'(voiceDelay), 32'd100);
        check_value("alloc0_vel",   32'(voiceVel),   32'd50);
        drop_on();
        check_value("go_one_cycle", 32'(voiceGo),    32'h00);

        pulse_on(10'd200, 8'd60);
        check_value("alloc1_go",   32'(voiceGo),    32'h02);
        check_value("alloc1_mask", 32'(activeMask), 32'h03);
        drop_on();

        // Release of tag 200 (voice 1)
        delay = 10'd200; noteOff = 1'b1; tick();
        check_value("rel_kill", 32'(voiceKill),  32'h02);
        check_value("rel_mask", 32'(activeMask), 32'h01);
        noteOff = 1'b0; tick();
        check_value("rel_kill_end", 32'(voiceKill), 32'h00);

        // noteOff with no matching tag
        delay = 10'd999; noteOff = 1'b1; tick();
        check_value("nomatch_kill", 32'(voiceKill),  32'h00);
        check_value("nomatch_mask", 32'(activeMask), 32'h01);
        noteOff = 1'b0; tick();

        // Voices 1 and 2 with tags 200, 300
        pulse_on(10'd200, 8'd61);
        check_value("realloc1_go", 32'(voiceGo), 32'h02);
        drop_on();
        pulse_on(10'd300, 8'd62);
        check_value("alloc2_go",   32'(voiceGo),    32'h04);
        check_value("alloc2_mask", 32'(activeMask), 32'h07);
        drop_on();

        // Positive saturation: 3 x 0x1FFFF
        set_all_data(18'h1FFFF);
        voiceReady = '1;
        tick();
        check_value("satpos_ready", 32'(ready),   32'h1);
        check_value("satpos_data",  32'(dataOut), 32'h1FFFF);

        // Hold while not received, with changing voice data
        for (int k = 0; k < 5; k++) begin
            set_all_data(18'(k * 1000 + 7));
            if (k == 4) set_all_data(18'h20000);
            tick();
        end
        check_value("hold_ready", 32'(ready),   32'h1);
        check_value("hold_data",  32'(dataOut), 32'h1FFFF);
        received = 1'b1; tick();
        check_value("recv_ready", 32'(ready), 32'h0);
        received = 1'b0; tick();

        // Negative saturation: 3 x -131072
        check_value("satneg_ready", 32'(ready),   32'h1);
        check_value("satneg_data",  32'(dataOut), 32'h20000);

        // Plain mix: 100 - 30 + 5 = 75, inactive voices carry 777
        set_all_data(18'd777);
        voiceData[0*SW +: SW] = 18'd100;
        voiceData[1*SW +: SW] = 18'h3FFE2;
        voiceData[2*SW +: SW] = 18'd5;
        voiceReady = 8'h03;
        received = 1'b1; tick();
        received = 1'b0; tick();
        check_value("partial_ready", 32'(ready), 32'h0);
        voiceReady = '1; tick();
        check_value("mix_ready", 32'(ready),   32'h1);
        check_value("mix_data",  32'(dataOut), 32'd75);
        received = 1'b1; tick();
        received = 1'b0; voiceReady = '0; tick();

        // Fill the pool
        for (int i = 3; i < NV; i++) begin
            pulse_on(10'(10 + i), 8'(i));
            drop_on();
        end
        check_value("full_mask", 32'(activeMask), 32'hFF);

        // First overflow
        pulse_on(10'd999, 8'd9);
        check_value("ovf1_dropped", 32'(dropped),   c_STEAL ? 32'h0 : 32'h1);
        check_value("ovf1_kill",    32'(voiceKill), c_STEAL ? 32'h01 : 32'h00);
        check_value("ovf1_go",      32'(voiceGo),   32'h00);
        drop_on();
        check_value("ovf1_dropped_end", 32'(dropped), 32'h0);
        check_value("ovf1_go2", 32'(voiceGo), c_STEAL ? 32'h01 : 32'h00);
        if (c_STEAL) check_value("ovf1_delay", 32'(voiceDelay), 32'd999);

        // Second overflow
        pulse_on(10'd998, 8'd8);
        check_value("ovf2_dropped", 32'(dropped),   c_STEAL ? 32'h0 : 32'h1);
        check_value("ovf2_kill",    32'(voiceKill), c_STEAL ? 32'h02 : 32'h00);
        drop_on();
        check_value("ovf2_go2", 32'(voiceGo), c_STEAL ? 32'h02 : 32'h00);

        // Collision on a full pool: release tag 300 (voice 2) with a noteOn
        delay = 10'd300; noteOn = 1'b1; noteOff = 1'b1; tick();
        check_value("coll_kill",    32'(voiceKill),  32'h04);
        check_value("coll_mask",    32'(activeMask), 32'hFB);
        check_value("coll_go",      32'(voiceGo),    32'h00);
        check_value("coll_dropped", 32'(dropped),    c_STEAL ? 32'h0 : 32'h1);
        noteOn = 1'b0; noteOff = 1'b0; tick();
        check_value("coll_go2",   32'(voiceGo),    c_STEAL ? 32'h04 : 32'h00);
        check_value("coll_mask2", 32'(activeMask), c_STEAL ? 32'hFF : 32'hFB);

        // Natural end of voice 3
        voicePrepped = 8'hF7; tick();
        voicePrepped = 8'hFF; tick();
        check_value("natend_mask", 32'(activeMask), c_STEAL ? 32'hF7 : 32'hF3);
        check_value("natend_kill", 32'(voiceKill),  32'h00);

        // Reallocation picks the lowest free voice
        pulse_on(10'd400, 8'd40);
        check_value("realloc_go", 32'(voiceGo), c_STEAL ? 32'h08 : 32'h04);
        drop_on();

        // Reset abandons an allocation in flight
        reset = 1'b1; delay = 10'd5; noteOn = 1'b1; tick();
        check_value("rstmid_go",   32'(voiceGo),    32'h00);
        check_value("rstmid_mask", 32'(activeMask), 32'h00);
        check_value("rstmid_ready", 32'(ready),     32'h0);
        reset = 1'b0; noteOn = 1'b0; tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
